debug_ctrl: RTL

DEBUG_CTRL -- requirements
Module: debug_ctrl

---
 rtl/dbg_pkg.sv | 62 ++++++
 rtl/dbg_cause_pri.sv | 35 +++
 rtl/debug_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared types and constants for the core debug controller.
package dbg_pkg;

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_HALTED,
      S_RESUME
   } dbg_state_e;

   // dcsr.cause encodings
   localparam logic [2:0] CAUSE_NONE    = 3'd0;
   localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
   localparam logic [2:0] CAUSE_TRIGGER = 3'd2;
   localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
   localparam logic [2:0] CAUSE_STEP    = 3'd4;

   localparam logic [3:0] XDEBUGVER = 4'd4;
   localparam logic [1:0] PRV_M     = 2'b11;

   // dcsr bit positions
   localparam int unsigned DCSR_XDEBUGVER_LSB = 28;
   localparam int unsigned DCSR_EBREAKM       = 15;
   localparam int unsigned DCSR_CAUSE_LSB     = 6;
   localparam int unsigned DCSR_STEP          = 2;
   localparam int unsigned DCSR_PRV_LSB       = 0;

   typedef struct packed {
      logic debug;
      logic halt_core;
      logic halted;
      logic running;
      logic redirect;
   } dbg_flags_t;

   // Status outputs implied by being in a given state
   function automatic dbg_flags_t state_flags(input dbg_state_e s);
      dbg_flags_t f;
      f = '0;
      case (s)
         S_RUN:    f.running = 1'b1;
         S_DRAIN:  begin f.debug = 1'b1; f.halt_core = 1'b1; end
         S_HALTED: begin f.debug = 1'b1; f.halt_core = 1'b1; f.halted = 1'b1; end
         S_RESUME: begin f.debug = 1'b1; f.redirect = 1'b1; end
         default:  f = '0;
      endcase
      return f;
   endfunction

   function automatic logic [31:0] pack_dcsr(input logic ebreakm, input logic [2:0] cause,
                                             input logic step);
      logic [31:0] d;
      d = '0;
      d[DCSR_XDEBUGVER_LSB +: 4] = XDEBUGVER;
      d[DCSR_EBREAKM]            = ebreakm;
      d[DCSR_CAUSE_LSB +: 3]     = cause;
      d[DCSR_STEP]               = step;
      d[DCSR_PRV_LSB +: 2]       = PRV_M;
      return d;
   endfunction

endpackage

// File: rtl/dbg_cause_pri.sv
// Halt-cause priority encoder: picks the dcsr.cause code and whether dpc
// captures the current pc (before-execution causes) or next_pc.
module dbg_cause_pri
   import dbg_pkg::*;
(
   input  logic       trigger,
   input  logic       ebreak,
   input  logic       ebreakm,
   input  logic       haltreq,
   input  logic       step_fire,
   output logic [2:0] cause,
   output logic       sel_pc,
   output logic       any
);

   // Fixed priority: trigger, enabled ebreak, haltreq, step
   always_comb begin
      cause  = CAUSE_NONE;
      sel_pc = 1'b0;
      if (trigger) begin
         cause  = CAUSE_TRIGGER;
         sel_pc = 1'b1;
      end else if (ebreak && ebreakm) begin
         cause  = CAUSE_EBREAK;
         sel_pc = 1'b1;
      end else if (haltreq) begin
         cause = CAUSE_HALTREQ;
      end else if (step_fire) begin
         cause = CAUSE_STEP;
      end
   end

   assign any = (cause != CAUSE_NONE);

endmodule

// File: rtl/debug_ctrl.sv
// Core-side debug mode controller: halt entry, pipeline drain, halted CSR
// access and single-cycle resume redirect.
module debug_ctrl
   import dbg_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        trigger_hit,
   input  logic        ebreak,
   input  logic        haltreq,
   input  logic        resumereq,
   input  logic        retire,
   input  logic [31:0] pc,
   input  logic [31:0] next_pc,
   input  logic        core_idle,
   input  logic [31:0] dcsr_in,
   input  logic [31:0] dpc_in,
   input  logic        dcsr_write,
   input  logic        dpc_write,
   output logic [31:0] dcsr_out,
   output logic [31:0] dpc_out,
   output logic        debug,
   output logic        halt_core,
   output logic        halted,
   output logic        running,
   output logic        resumeack,
   output logic        redirect,
   output logic [31:0] redirect_pc
);

   dbg_state_e  state;
   dbg_flags_t  flags;
   logic [31:1] dpc_q;
   logic [2:0]  cause_q;
   logic        ebreakm_q;
   logic        step_q;
   logic        step_pending;

   logic        trigger_live;
   logic        step_fire;
   logic [2:0]  new_cause;
   logic        sel_pc;
   logic        halt_now;
   logic        unused_bits;

   assign trigger_live = trigger_hit & ~flags.debug;
   assign step_fire    = step_pending & retire;

   dbg_cause_pri u_cause_pri (
      .trigger   (trigger_live),
      .ebreak    (ebreak),
      .ebreakm   (ebreakm_q),
      .haltreq   (haltreq),
      .step_fire (step_fire),
      .cause     (new_cause),
      .sel_pc    (sel_pc),
      .any       (halt_now)
   );

   // Debug FSM with registered status flags and the dcsr/dpc state it owns
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_RUN;
         flags        <= state_flags(S_RUN);
         dpc_q        <= '0;
         cause_q      <= CAUSE_NONE;
         ebreakm_q    <= 1'b0;
         step_q       <= 1'b0;
         step_pending <= 1'b0;
         resumeack    <= 1'b0;
      end else begin
         if (!resumereq)
            resumeack <= 1'b0;
         case (state)
            S_RUN: begin
               if (halt_now) begin
                  state        <= S_DRAIN;
                  flags        <= state_flags(S_DRAIN);
                  cause_q      <= new_cause;
                  dpc_q        <= sel_pc ? pc[31:1] : next_pc[31:1];
                  step_pending <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (core_idle) begin
                  state <= S_HALTED;
                  flags <= state_flags(S_HALTED);
               end
            end
            S_HALTED: begin
               if (dcsr_write) begin
                  ebreakm_q <= dcsr_in[DCSR_EBREAKM];
                  step_q    <= dcsr_in[DCSR_STEP];
               end
               if (dpc_write)
                  dpc_q <= dpc_in[31:1];
               if (resumereq && !haltreq) begin
                  state     <= S_RESUME;
                  flags     <= state_flags(S_RESUME);
                  resumeack <= 1'b1;
               end
            end
            S_RESUME: begin
               state        <= S_RUN;
               flags        <= state_flags(S_RUN);
               step_pending <= step_q;
            end
            default: begin
               state <= S_RUN;
               flags <= state_flags(S_RUN);
            end
         endcase
      end
   end

   assign debug       = flags.debug;
   assign halt_core   = flags.halt_core;
   assign halted      = flags.halted;
   assign running     = flags.running;
   assign redirect    = flags.redirect;
   assign dcsr_out    = pack_dcsr(ebreakm_q, cause_q, step_q);
   assign dpc_out     = {dpc_q, 1'b0};
   assign redirect_pc = dpc_out;

   // Input bits with no storage behind them
   assign unused_bits = ^{dcsr_in[31:16], dcsr_in[14:3], dcsr_in[1:0],
                          dpc_in[0], pc[0], next_pc[0]};

endmodule
